// File: rtl/seg_pkg.sv
// Shared seven-segment constants and decoder FSM state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seg_pkg;

    // Active-low patterns, bit0=a ... bit6=g, as driven by the value-to-HEX encoder
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h18;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        WAIT_LO = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/hex_segment_lookup.sv
// Maps a 7-bit active-low segment pattern to its hex digit plus a legal flag.
// Latency: purely combinational.
// Backpressure: none; no handshake at this level.
module hex_segment_lookup
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_digit,
    output logic       o_legal
);

    // Inverse of the encoder table; anything not in the table is illegal and reads as 0
    always_comb begin
        o_digit = 4'h0;
        o_legal = 1'b1;
        case (i_seg)
            SEG_0:   o_digit = 4'h0;
            SEG_1:   o_digit = 4'h1;
            SEG_2:   o_digit = 4'h2;
            SEG_3:   o_digit = 4'h3;
            SEG_4:   o_digit = 4'h4;
            SEG_5:   o_digit = 4'h5;
            SEG_6:   o_digit = 4'h6;
            SEG_7:   o_digit = 4'h7;
            SEG_8:   o_digit = 4'h8;
            SEG_9:   o_digit = 4'h9;
            SEG_A:   o_digit = 4'hA;
            SEG_B:   o_digit = 4'hB;
            SEG_C:   o_digit = 4'hC;
            SEG_D:   o_digit = 4'hD;
            SEG_E:   o_digit = 4'hE;
            SEG_F:   o_digit = 4'hF;
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/hex_segment_decoder.sv
// Decodes a stream of segment patterns into digits and pairs them (high first) into bytes.
// Latency: byte_valid rises the cycle after the low-digit accept; 3 cycles per byte minimum.
// Backpressure: while a byte is held seg_ready is low; byte_out stays stable until taken.
module hex_segment_decoder
    import seg_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    input  logic             seg_valid,
    output logic             seg_ready,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_hi;
    logic [7:0]       r_byte;
    logic             r_err;
    logic [ERR_W-1:0] r_err_count;
    logic [3:0]       w_digit;
    logic             w_legal;
    logic             w_accept;
    logic             w_xfer;

    hex_segment_lookup u_lookup (
        .i_seg   (seg_in),
        .o_digit (w_digit),
        .o_legal (w_legal)
    );

    assign seg_ready  = (r_state != FULL);
    assign byte_valid = (r_state == FULL);
    assign byte_out   = r_byte;
    assign err        = r_err;
    assign err_count  = r_err_count;
    assign w_accept   = seg_valid & seg_ready;
    assign w_xfer     = byte_valid & byte_ready;

    // Next-state: advance only on a handshake; an illegal low digit resyncs to the high slot
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_HI: if (w_accept && w_legal) w_next_state = WAIT_LO;
            WAIT_LO: if (w_accept)            w_next_state = w_legal ? FULL : WAIT_HI;
            FULL:    if (w_xfer)              w_next_state = WAIT_HI;
            default:                          w_next_state = WAIT_HI;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= WAIT_HI;
        else       r_state <= w_next_state;
    end

    // Nibble/byte capture; a resync clears the stale high nibble
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hi   <= 4'h0;
            r_byte <= 8'h00;
        end else if (w_accept) begin
            if (r_state == WAIT_HI && w_legal) begin
                r_hi <= w_digit;
            end else if (r_state == WAIT_LO) begin
                if (w_legal) r_byte <= {r_hi, w_digit};
                else         r_hi   <= 4'h0;
            end
        end
    end

    // Error pulse and saturating illegal-pattern counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err <= w_accept & ~w_legal;
            if (w_accept && !w_legal && (r_err_count != {ERR_W{1'b1}}))
                r_err_count <= r_err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_hex_segment_decoder.sv
module tb_hex_segment_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic       seg_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       err;
    logic [7:0] err_count;

    logic [6:0] s_seg_in;
    logic       s_seg_valid;
    logic       s_seg_ready;
    logic [7:0] s_byte_out;
    logic       s_byte_valid;
    logic       s_err;
    logic [1:0] s_err_count;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];

    logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [6:0] hi;
        logic [6:0] lo;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[6];

    always #5 clock = ~clock;

    hex_segment_decoder #(.ERR_W(8)) dut (
        .clock(clock), .reset(reset), .seg_in(seg_in), .seg_valid(seg_valid),
        .seg_ready(seg_ready), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .err(err), .err_count(err_count)
    );

    hex_segment_decoder #(.ERR_W(2)) u_sat (
        .clock(clock), .reset(reset), .seg_in(s_seg_in), .seg_valid(s_seg_valid),
        .seg_ready(s_seg_ready), .byte_out(s_byte_out), .byte_valid(s_byte_valid),
        .byte_ready(1'b1), .err(s_err), .err_count(s_err_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard: compare every byte transfer against the queued expectation
    always @(negedge clock) begin
        if (!reset && byte_valid && byte_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte got=%0h expected=none", byte_out);
            end else begin
                chk("byte_out", {24'h0, byte_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Present one pattern and hold it until accepted; returns 1 time unit after the accept edge
    task automatic send(input logic [6:0] p);
        int n = 0;
        seg_in    = p;
        seg_valid = 1'b1;
        @(negedge clock);
        while (!seg_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clock);
        #1;
        seg_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        seg_in      = 7'h7F;
        seg_valid   = 1'b0;
        byte_ready  = 1'b1;
        s_seg_in    = 7'h7F;
        s_seg_valid = 1'b0;
        vecs[0] = '{7'h79, 7'h0E, 8'h1F};
        vecs[1] = '{7'h40, 7'h40, 8'h00};
        vecs[2] = '{7'h0E, 7'h0E, 8'hFF};
        vecs[3] = '{7'h08, 7'h03, 8'hAB};
        vecs[4] = '{7'h46, 7'h21, 8'hCD};
        vecs[5] = '{7'h02, 7'h18, 8'h69};
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_seg_ready",  {31'h0, seg_ready},  32'd1);
        chk("rst_byte_valid", {31'h0, byte_valid}, 32'd0);
        chk("rst_byte_out",   {24'h0, byte_out},   32'h00);
        chk("rst_err",        {31'h0, err},        32'd0);
        chk("rst_err_count",  {24'h0, err_count},  32'd0);

        // Table of hand-picked pairs
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp);
            send(vecs[i].hi);
            send(vecs[i].lo);
        end

        // Round trip of every byte value
        for (int b = 0; b < 256; b++) begin
            exp_q.push_back(8'(b));
            send(enc[b >> 4]);
            send(enc[b & 15]);
        end
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            tick();
        end
        chk("roundtrip_drained", exp_q.size(), 32'd0);

        // Backpressure: 3, d held for 5 cycles with a pattern pending on the input
        byte_ready = 1'b0;
        exp_q.push_back(8'h3D);
        send(7'h30);
        send(7'h21);
        seg_in    = 7'h40;
        seg_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            chk("bp_byte_valid", {31'h0, byte_valid}, 32'd1);
            chk("bp_byte_out",   {24'h0, byte_out},   32'h3D);
            chk("bp_seg_ready",  {31'h0, seg_ready},  32'd0);
        end
        @(posedge clock);
        #1;
        seg_valid  = 1'b0;
        byte_ready = 1'b1;
        tick();
        chk("bp_after_valid", {31'h0, byte_valid}, 32'd0);
        chk("bp_after_ready", {31'h0, seg_ready},  32'd1);
        chk("bp_drained",     exp_q.size(),        32'd0);

        // Resync: legal high then illegal low
        send(7'h12);
        send(7'h7F);
        chk("resync_err",       {31'h0, err},       32'd1);
        chk("resync_err_count", {24'h0, err_count}, 32'd1);
        tick();
        chk("resync_err_clear", {31'h0, err},        32'd0);
        chk("resync_no_byte",   {31'h0, byte_valid}, 32'd0);
        exp_q.push_back(8'hAB);
        send(7'h08);
        send(7'h03);

        // Back-to-back illegal in WAIT_HI
        send(7'h7F);
        chk("ill1_err",   {31'h0, err},       32'd1);
        chk("ill1_count", {24'h0, err_count}, 32'd2);
        send(7'h7F);
        chk("ill2_err",   {31'h0, err},       32'd1);
        chk("ill2_count", {24'h0, err_count}, 32'd3);
        tick();
        chk("ill_err_clear", {31'h0, err}, 32'd0);
        exp_q.push_back(8'h00);
        send(7'h40);
        send(7'h40);

        // Saturation on the 2-bit counter instance
        s_seg_in    = 7'h7F;
        s_seg_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("sat_err",   {31'h0, s_err},       32'd1);
            chk("sat_count", {30'h0, s_err_count}, (k < 3) ? k : 3);
        end
        s_seg_valid = 1'b0;
        tick();
        chk("sat_err_clear", {31'h0, s_err},       32'd0);
        chk("sat_hold",      {30'h0, s_err_count}, 32'd3);

        // Reset mid-byte with a pattern offered during reset
        send(7'h24);
        seg_in    = 7'h19;
        seg_valid = 1'b1;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        seg_valid = 1'b0;
        chk("mid_rst_seg_ready",  {31'h0, seg_ready},  32'd1);
        chk("mid_rst_byte_valid", {31'h0, byte_valid}, 32'd0);
        chk("mid_rst_byte_out",   {24'h0, byte_out},   32'h00);
        chk("mid_rst_err",        {31'h0, err},        32'd0);
        chk("mid_rst_err_count",  {24'h0, err_count},  32'd0);
        exp_q.push_back(8'h47);
        send(7'h19);
        send(7'h78);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            n++;
            tick();
        end
        chk("final_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
